// File: rtl/axi_fft_master_pkg.sv
// ---------------------------------------------------------------------------
// axi_fft_master_pkg
// Shared types and fixed AXI encodings for the FFT bridge master.
//   master_fsm : job sequencer states
//   AXSIZE_2B  : AxSIZE for 16-bit beats
//   BURST_INCR : AxBURST for incrementing bursts
//   WSTRB_ALL  : both byte lanes of a 16-bit beat enabled
//   CNT_W      : beat counter width (covers 256 beats without wrapping)
// ---------------------------------------------------------------------------
package axi_fft_master_pkg;

    typedef enum logic [2:0] {
        m_IDLE,
        m_AW,
        m_W,
        m_B,
        m_WAIT_CALC,
        m_AR,
        m_R,
        m_DONE
    } master_fsm;

    localparam logic [2:0] AXSIZE_2B  = 3'b001;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] WSTRB_ALL  = 2'b11;
    localparam int         CNT_W      = 9;

endpackage

// File: rtl/axi_reg_slice.sv
// ---------------------------------------------------------------------------
// axi_reg_slice
// One-entry valid/ready pipeline register. Accepts a new word whenever it is
// empty or its current word is being taken downstream in the same cycle.
//   i_clk, i_rstn     : clock, asynchronous active-low reset
//   i_data, i_valid   : upstream word and valid
//   o_ready           : upstream may transfer this cycle
//   o_data, o_valid   : registered word and valid
//   i_ready           : downstream takes the registered word
// ---------------------------------------------------------------------------
module axi_reg_slice #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_ready = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
        end
    end

    // NOTE: the payload register is deliberately left without reset; it is
    // only ever observed while r_valid is set, and dropping the reset keeps it
    // a plain enable flop.
    always_ff @(posedge i_clk) begin
        if (o_ready && i_valid) begin
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/axi_fft_master.sv
// ---------------------------------------------------------------------------
// axi_fft_master
// AXI4 initiator running one FFT job per start: INCR write burst of 16-bit
// samples from a stream, wait for BRESP, wait for calc done, INCR read burst
// of results forwarded to a stream. Single outstanding transaction.
//   i_clk, i_rstn                 : clock, asynchronous active-low reset
//   i_start, i_len, i_waddr/raddr : job command (sampled in IDLE)
//   i_calc_done                   : FFT finished (level or pulse)
//   i_s_* / o_s_ready             : sample stream in
//   o_r_* / i_r_ready             : result stream out
//   AW/W/B/AR/R                   : AXI4 master channels
//   o_busy, o_done, o_error       : status (done is a pulse, error sticky)
// ---------------------------------------------------------------------------
module axi_fft_master
    import axi_fft_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_W_WIDTH = 2,
    parameter int ID_R_WIDTH = 2,
    parameter int AXI_ID     = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [7:0]            i_len,
    input  logic [11:0]           i_waddr,
    input  logic [11:0]           i_raddr,
    input  logic                  i_calc_done,
    input  logic [15:0]           i_s_data,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    output logic [DATA_WIDTH-1:0] o_r_data,
    output logic                  o_r_valid,
    input  logic                  i_r_ready,
    output logic [11:0]           o_AWADDR,
    output logic [7:0]            o_AWLEN,
    output logic [2:0]            o_AWSIZE,
    output logic [1:0]            o_AWBURST,
    output logic [ID_W_WIDTH-1:0] o_AWID,
    output logic                  o_AWVALID,
    input  logic                  i_AWREADY,
    output logic [15:0]           o_WDATA,
    output logic [1:0]            o_WSTRB,
    output logic                  o_WVALID,
    output logic                  o_WLAST,
    input  logic                  i_WREADY,
    input  logic                  i_BVALID,
    input  logic [ID_W_WIDTH-1:0] i_BID,
    output logic                  o_BREADY,
    output logic [11:0]           o_ARADDR,
    output logic [7:0]            o_ARLEN,
    output logic [2:0]            o_ARSIZE,
    output logic [1:0]            o_ARBURST,
    output logic [ID_R_WIDTH-1:0] o_ARID,
    output logic                  o_ARVALID,
    input  logic                  i_ARREADY,
    input  logic [DATA_WIDTH-1:0] i_RDATA,
    input  logic [ID_R_WIDTH-1:0] i_RID,
    input  logic                  i_RVALID,
    input  logic                  i_RLAST,
    output logic                  o_RREADY,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam logic [ID_W_WIDTH-1:0] W_ID = ID_W_WIDTH'(AXI_ID);
    localparam logic [ID_R_WIDTH-1:0] R_ID = ID_R_WIDTH'(AXI_ID);

    master_fsm        r_state, w_next;
    logic [7:0]       r_len;
    logic [11:0]      r_waddr, r_raddr;
    logic [CNT_W-1:0] r_wcnt, r_rcnt;
    logic             r_rd_done, r_error;

    logic [CNT_W-1:0] w_len_ext;
    logic             w_w_load_en, w_ws_ready, w_s_fire, w_wlast_fire;
    logic [16:0]      w_ws_out;
    logic             w_r_accept_en, w_rs_ready, w_r_fire;

    assign w_len_ext = {1'b0, r_len};

    // Write path: the slice stores {WLAST, WDATA}; loads stop once len+1
    // samples have been taken so the burst never overruns.
    assign w_w_load_en  = (r_state == m_W) && (r_wcnt <= w_len_ext);
    assign o_s_ready    = w_ws_ready && w_w_load_en;
    assign w_s_fire     = i_s_valid && o_s_ready;
    assign w_wlast_fire = o_WVALID && i_WREADY && o_WLAST;

    axi_reg_slice #(.WIDTH(17)) u_w_slice (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_data  ({r_wcnt == w_len_ext, i_s_data}),
        .i_valid (i_s_valid && w_w_load_en),
        .o_ready (w_ws_ready),
        .o_data  (w_ws_out),
        .o_valid (o_WVALID),
        .i_ready (i_WREADY)
    );

    assign o_WDATA = w_ws_out[15:0];
    assign o_WLAST = w_ws_out[16];

    // Read path: stop accepting after the final beat and let the slice drain.
    assign w_r_accept_en = (r_state == m_R) && !r_rd_done;
    assign o_RREADY      = w_rs_ready && w_r_accept_en;
    assign w_r_fire      = i_RVALID && o_RREADY;

    axi_reg_slice #(.WIDTH(DATA_WIDTH)) u_r_slice (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_data  (i_RDATA),
        .i_valid (i_RVALID && w_r_accept_en),
        .o_ready (w_rs_ready),
        .o_data  (o_r_data),
        .o_valid (o_r_valid),
        .i_ready (i_r_ready)
    );

    assign o_AWADDR  = r_waddr;
    assign o_AWLEN   = r_len;
    assign o_AWSIZE  = AXSIZE_2B;
    assign o_AWBURST = BURST_INCR;
    assign o_AWID    = W_ID;
    assign o_WSTRB   = WSTRB_ALL;
    assign o_ARADDR  = r_raddr;
    assign o_ARLEN   = r_len;
    assign o_ARSIZE  = AXSIZE_2B;
    assign o_ARBURST = BURST_INCR;
    assign o_ARID    = R_ID;
    assign o_error   = r_error;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= m_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves w_next
        // unassigned and infers a latch.
        w_next = r_state;
        case (r_state)
            m_IDLE:      if (i_start)                    w_next = m_AW;
            m_AW:        if (i_AWREADY)                  w_next = m_W;
            m_W:         if (w_wlast_fire)               w_next = m_B;
            m_B:         if (i_BVALID)                   w_next = m_WAIT_CALC;
            m_WAIT_CALC: if (i_calc_done)                w_next = m_AR;
            m_AR:        if (i_ARREADY)                  w_next = m_R;
            m_R:         if (r_rd_done && !o_r_valid)    w_next = m_DONE;
            m_DONE:                                      w_next = m_IDLE;
            default:                                     w_next = m_IDLE;
        endcase
    end

    always_comb begin
        o_AWVALID = (r_state == m_AW);
        o_BREADY  = (r_state == m_B);
        o_ARVALID = (r_state == m_AR);
        o_busy    = (r_state != m_IDLE);
        o_done    = (r_state == m_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_len     <= '0;
            r_waddr   <= '0;
            r_raddr   <= '0;
            r_wcnt    <= '0;
            r_rcnt    <= '0;
            r_rd_done <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            if (r_state == m_IDLE && i_start) begin
                r_len     <= i_len;
                r_waddr   <= i_waddr;
                r_raddr   <= i_raddr;
                r_wcnt    <= '0;
                r_rcnt    <= '0;
                r_rd_done <= 1'b0;
                r_error   <= 1'b0;
            end
            if (w_s_fire) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (r_state == m_B && i_BVALID && i_BID != W_ID) begin
                r_error <= 1'b1;
            end
            if (w_r_fire) begin
                r_rcnt <= r_rcnt + 1'b1;
                // Early RLAST, missing RLAST and wrong RID are all sticky.
                if (i_RID != R_ID || (i_RLAST && r_rcnt < w_len_ext) ||
                    (!i_RLAST && r_rcnt == w_len_ext)) begin
                    r_error <= 1'b1;
                end
                if (i_RLAST || r_rcnt == w_len_ext) begin
                    r_rd_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_fft_master.sv
// ---------------------------------------------------------------------------
// tb_axi_fft_master
// Directed sequence of FFT jobs against a behavioural bridge: sample list in,
// expected W beats and result list out, error flag derived from the injected
// protocol faults.
// ---------------------------------------------------------------------------
module tb_axi_fft_master;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_start;
    logic [7:0]  i_len;
    logic [11:0] i_waddr, i_raddr;
    logic        i_calc_done;
    logic [15:0] i_s_data;
    logic        i_s_valid, o_s_ready;
    logic [31:0] o_r_data;
    logic        o_r_valid, i_r_ready;
    logic [11:0] o_AWADDR;
    logic [7:0]  o_AWLEN;
    logic [2:0]  o_AWSIZE;
    logic [1:0]  o_AWBURST, o_AWID;
    logic        o_AWVALID, i_AWREADY;
    logic [15:0] o_WDATA;
    logic [1:0]  o_WSTRB;
    logic        o_WVALID, o_WLAST, i_WREADY;
    logic        i_BVALID;
    logic [1:0]  i_BID;
    logic        o_BREADY;
    logic [11:0] o_ARADDR;
    logic [7:0]  o_ARLEN;
    logic [2:0]  o_ARSIZE;
    logic [1:0]  o_ARBURST, o_ARID;
    logic        o_ARVALID, i_ARREADY;
    logic [31:0] i_RDATA;
    logic [1:0]  i_RID;
    logic        i_RVALID, i_RLAST, o_RREADY;
    logic        o_busy, o_done, o_error;

    int n_assert = 0;
    int n_fail   = 0;

    axi_fft_master #(
        .DATA_WIDTH (32),
        .ID_W_WIDTH (2),
        .ID_R_WIDTH (2),
        .AXI_ID     (1)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_waddr     (i_waddr),
        .i_raddr     (i_raddr),
        .i_calc_done (i_calc_done),
        .i_s_data    (i_s_data),
        .i_s_valid   (i_s_valid),
        .o_s_ready   (o_s_ready),
        .o_r_data    (o_r_data),
        .o_r_valid   (o_r_valid),
        .i_r_ready   (i_r_ready),
        .o_AWADDR    (o_AWADDR),
        .o_AWLEN     (o_AWLEN),
        .o_AWSIZE    (o_AWSIZE),
        .o_AWBURST   (o_AWBURST),
        .o_AWID      (o_AWID),
        .o_AWVALID   (o_AWVALID),
        .i_AWREADY   (i_AWREADY),
        .o_WDATA     (o_WDATA),
        .o_WSTRB     (o_WSTRB),
        .o_WVALID    (o_WVALID),
        .o_WLAST     (o_WLAST),
        .i_WREADY    (i_WREADY),
        .i_BVALID    (i_BVALID),
        .i_BID       (i_BID),
        .o_BREADY    (o_BREADY),
        .o_ARADDR    (o_ARADDR),
        .o_ARLEN     (o_ARLEN),
        .o_ARSIZE    (o_ARSIZE),
        .o_ARBURST   (o_ARBURST),
        .o_ARID      (o_ARID),
        .o_ARVALID   (o_ARVALID),
        .i_ARREADY   (i_ARREADY),
        .i_RDATA     (i_RDATA),
        .i_RID       (i_RID),
        .i_RVALID    (i_RVALID),
        .i_RLAST     (i_RLAST),
        .o_RREADY    (o_RREADY),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        i_start     = 1'b0;
        i_calc_done = 1'b0;
        i_s_valid   = 1'b0;
        i_s_data    = '0;
        i_r_ready   = 1'b0;
        i_AWREADY   = 1'b0;
        i_WREADY    = 1'b0;
        i_BVALID    = 1'b0;
        i_BID       = '0;
        i_ARREADY   = 1'b0;
        i_RDATA     = '0;
        i_RID       = '0;
        i_RVALID    = 1'b0;
        i_RLAST     = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_awvalid"}, 64'(o_AWVALID), 64'(0));
        check({tag, "_wvalid"},  64'(o_WVALID),  64'(0));
        check({tag, "_s_ready"}, 64'(o_s_ready), 64'(0));
        check({tag, "_arvalid"}, 64'(o_ARVALID), 64'(0));
        check({tag, "_busy"},    64'(o_busy),    64'(0));
    endtask

    // mode 0: bridge and streams always ready
    // mode 1: WREADY toggles, sample valid low every 3rd cycle, r_ready 1 of 3
    // mode 2: every handshake signal random
    task automatic run_job(input int len, input logic [11:0] waddr, input logic [11:0] raddr,
                           input logic [1:0] bid, input int rlast_at, input int mode,
                           input bit fixed, input bit hold_start, input bit calc_held,
                           input int abort_w);
        logic [15:0] samples[$];
        logic [31:0] rdata[$];
        logic [16:0] wq[$];
        logic [31:0] got[$];
        int          s_idx, r_sent, w_n, aw_n, ar_n, done_n, tail, n_rbeats, calc_wait, bad_beat;
        bit          b_done, got_wlast, ar_done, ar_early, calc_fired, rv, finished;
        bit          prev_wstall, err_at_done, exp_err;
        logic [16:0] prev_w;
        logic [11:0] aw_addr, ar_addr;
        logic [7:0]  aw_len, ar_len;
        logic [2:0]  aw_size, ar_size;
        logic [1:0]  aw_burst, ar_burst, aw_id, ar_id;

        s_idx = 0; r_sent = 0; w_n = 0; aw_n = 0; ar_n = 0; done_n = 0; tail = 0; bad_beat = 0;
        b_done = 0; got_wlast = 0; ar_done = 0; ar_early = 0; calc_fired = 0; rv = 0;
        finished = 0; prev_wstall = 0; err_at_done = 0; prev_w = '0;
        aw_addr = '0; ar_addr = '0; aw_len = '0; ar_len = '0; aw_size = '0; ar_size = '0;
        aw_burst = '0; ar_burst = '0; aw_id = '0; ar_id = '0;
        calc_wait = int'($urandom_range(0, 3));
        n_rbeats  = ((rlast_at < len) ? rlast_at : len) + 1;
        exp_err   = (bid != 2'd1) || (rlast_at != len);
        for (int i = 0; i <= len; i++) begin
            samples.push_back(fixed ? 16'(16'h1111 * (i + 1)) : 16'($urandom));
            rdata.push_back(fixed ? 32'(32'hA0 + i) : $urandom);
        end

        for (int cyc = 0; cyc < 8000 && !finished; cyc++) begin
            @(negedge i_clk);
            // Command fields scrambled after cycle 0 to prove they are latched.
            i_start = (cyc == 0) || (hold_start && done_n == 0);
            i_len   = (cyc == 0) ? 8'(len) : 8'($urandom);
            i_waddr = (cyc == 0) ? waddr : 12'($urandom);
            i_raddr = (cyc == 0) ? raddr : 12'($urandom);

            if (s_idx <= len && (mode == 0 || (mode == 1 && cyc % 3 != 2) ||
                                 (mode == 2 && $urandom_range(0, 3) != 0))) begin
                i_s_valid = 1'b1;
                i_s_data  = samples[s_idx];
            end else begin
                i_s_valid = 1'b0;
                i_s_data  = 16'($urandom);
            end

            i_WREADY  = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom);
            i_AWREADY = (mode != 2) ? 1'b1 : 1'($urandom);
            i_ARREADY = (mode != 2) ? 1'b1 : 1'($urandom);
            i_BVALID  = got_wlast && !b_done;
            i_BID     = bid;

            if (calc_held) begin
                i_calc_done = 1'b1;
            end else if (b_done && !calc_fired && calc_wait == 0) begin
                i_calc_done = 1'b1;
                calc_fired  = 1;
            end else begin
                i_calc_done = 1'b0;
                if (b_done && !calc_fired) calc_wait--;
            end

            if (ar_done && r_sent < n_rbeats) begin
                if (!rv) rv = (mode != 2) ? 1'b1 : 1'($urandom);
            end else begin
                rv = 0;
            end
            i_RVALID = rv;
            i_RID    = 2'd1;
            if (rv) begin
                i_RDATA = rdata[r_sent];
                i_RLAST = (r_sent == rlast_at);
            end else begin
                i_RDATA = $urandom;
                i_RLAST = 1'b0;
            end

            i_r_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom);

            if (abort_w >= 0 && w_n == abort_w) begin
                check("pre_reset_wvalid", 64'(o_WVALID), 64'(1));
                i_rstn = 1'b0;
                #1;
                check_quiet("mid_reset");
                idle_inputs();
                @(negedge i_clk);
                i_rstn = 1'b1;
                return;
            end

            #1;
            if (cyc == 1) begin
                check("awvalid_latency", 64'(o_AWVALID), 64'(1));
                check("busy_in_job",     64'(o_busy),    64'(1));
                check("error_cleared",   64'(o_error),   64'(0));
            end
            if (prev_wstall && (!o_WVALID || {o_WLAST, o_WDATA} !== prev_w)) bad_beat++;
            if (o_ARVALID && !b_done) ar_early = 1;

            if (i_s_valid && o_s_ready) s_idx++;
            if (o_AWVALID && i_AWREADY) begin
                aw_n++;
                aw_addr = o_AWADDR; aw_len = o_AWLEN; aw_size = o_AWSIZE;
                aw_burst = o_AWBURST; aw_id = o_AWID;
            end
            if (o_WVALID && i_WREADY) begin
                wq.push_back({o_WLAST, o_WDATA});
                w_n++;
                if (o_WSTRB !== 2'b11) bad_beat++;
                if (o_WLAST) got_wlast = 1;
            end
            prev_wstall = o_WVALID && !i_WREADY;
            prev_w      = {o_WLAST, o_WDATA};
            if (i_BVALID && o_BREADY) b_done = 1;
            if (o_ARVALID && i_ARREADY) begin
                ar_n++;
                ar_done = 1;
                ar_addr = o_ARADDR; ar_len = o_ARLEN; ar_size = o_ARSIZE;
                ar_burst = o_ARBURST; ar_id = o_ARID;
            end
            if (i_RVALID && o_RREADY) begin
                r_sent++;
                rv = 0;
            end
            if (o_r_valid && i_r_ready) got.push_back(o_r_data);
            if (o_done) begin
                done_n++;
                err_at_done = o_error;
            end
            if (done_n > 0) begin
                tail++;
                if (tail == 4) finished = 1;
            end
        end

        check("done_pulses", 64'(done_n),   64'(1));
        check("aw_count",    64'(aw_n),     64'(1));
        check("awaddr",      64'(aw_addr),  64'(waddr));
        check("awlen",       64'(aw_len),   64'(len));
        check("awsize",      64'(aw_size),  64'(1));
        check("awburst",     64'(aw_burst), 64'(1));
        check("awid",        64'(aw_id),    64'(1));
        check("ar_count",    64'(ar_n),     64'(1));
        check("araddr",      64'(ar_addr),  64'(raddr));
        check("arlen",       64'(ar_len),   64'(len));
        check("arsize",      64'(ar_size),  64'(1));
        check("arburst",     64'(ar_burst), 64'(1));
        check("arid",        64'(ar_id),    64'(1));
        check("ar_after_b",  64'(ar_early), 64'(0));
        check("w_protocol",  64'(bad_beat), 64'(0));
        check("w_count",     64'(wq.size()), 64'(len + 1));
        for (int i = 0; i < wq.size() && i <= len; i++)
            check("w_beat", 64'(wq[i]), 64'({(i == len), samples[i]}));
        check("r_count",     64'(got.size()), 64'(n_rbeats));
        for (int i = 0; i < got.size() && i < n_rbeats; i++)
            check("r_beat", 64'(got[i]), 64'(rdata[i]));
        check("error_flag",  64'(err_at_done), 64'(exp_err));
        check("idle_after",  64'(o_busy), 64'(0));
        idle_inputs();
    endtask

    initial begin
        i_rstn  = 1'b0;
        i_len   = '0;
        i_waddr = '0;
        i_raddr = '0;
        idle_inputs();
        repeat (3) @(negedge i_clk);
        check_quiet("reset");
        check("reset_done",   64'(o_done),    64'(0));
        check("reset_error",  64'(o_error),   64'(0));
        check("reset_bready", 64'(o_BREADY),  64'(0));
        check("reset_rready", 64'(o_RREADY),  64'(0));
        check("reset_rvalid", 64'(o_r_valid), 64'(0));
        i_rstn = 1'b1;
        @(negedge i_clk);

        // Nominal job with fixed samples and results.
        run_job(3, 12'h000, 12'h000, 2'd1, 3, 0, 1'b1, 1'b0, 1'b0, -1);
        // Fixed backpressure patterns.
        run_job(3, 12'h040, 12'h080, 2'd1, 3, 1, 1'b1, 1'b0, 1'b0, -1);
        // Single-beat bursts.
        run_job(0, 12'h123, 12'h456, 2'd1, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        // Wrong BID: job completes with sticky error.
        run_job(3, 12'h010, 12'h020, 2'd2, 3, 2, 1'b0, 1'b0, 1'b0, -1);
        repeat (3) @(negedge i_clk);
        check("error_sticky", 64'(o_error), 64'(1));
        // Next start clears the error.
        run_job(2, 12'h200, 12'h300, 2'd1, 2, 2, 1'b0, 1'b0, 1'b0, -1);
        // Early RLAST on beat 1 of 4.
        run_job(3, 12'h008, 12'h00C, 2'd1, 1, 0, 1'b0, 1'b0, 1'b0, -1);
        // Reset after two write beats, then a clean job.
        run_job(3, 12'h100, 12'h100, 2'd1, 3, 0, 1'b0, 1'b0, 1'b0, 2);
        run_job(3, 12'h0F0, 12'h0E0, 2'd1, 3, 2, 1'b0, 1'b0, 1'b0, -1);
        // Start and calc_done held high throughout.
        run_job(5, 12'h400, 12'h500, 2'd1, 5, 2, 1'b0, 1'b1, 1'b1, -1);
        // Maximum burst.
        run_job(255, 12'h000, 12'h800, 2'd1, 255, 2, 1'b0, 1'b0, 1'b0, -1);
        // A few random short jobs.
        for (int j = 0; j < 4; j++) begin
            int l;
            l = int'($urandom_range(0, 24));
            run_job(l, 12'($urandom), 12'($urandom), 2'd1, l, int'($urandom_range(0, 2)),
                    1'b0, 1'b0, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
